mont_exp_param: RTL and testbench
=================================

Name: mont_exp_param

Overview:
- Parametrised modular exponentiation engine: result = base^exp mod n.
- Uses left-to-right square-and-multiply over an embedded radix-2 bit-serial Montgomery multiplier.
- Next generation of the RSA exponentiation core. Adds configurable operand and exponent widths, a start/busy/done handshake, host-supplied R^2 for correct Montgomery-domain conversion, leading-zero skipping, an exp==0 case and an even-modulus error flag.
- Sits between the RSA register/control front end and the key/message storage.

Parameters:
- WIDTH, 2048, operand width of base, modulus, r2 and result; R = 2^WIDTH.
- EXP_WIDTH, 2048, exponent width; may be smaller than WIDTH (e.g. 17 for public exponents).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- base  in  WIDTH  message/ciphertext; must be < n.
- exp  in  EXP_WIDTH  exponent.
- n  in  WIDTH  modulus; must be odd.
- r2  in  WIDTH  R^2 mod n, precomputed by host.
- busy  out  1  high from cycle after accept until done cycle inclusive.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  set with done when n is even; cleared on next accepted start.
- result  out  WIDTH  base^exp mod n; held until next accepted start.

Behaviour:
- Reset (sys_rst_n=0 at a clk edge): busy=0, done=0, err=0, result=0, state=IDLE, all internal registers cleared. Applies even mid-operation; any operation in progress is abandoned with no done pulse.
- Start handling:
  - start with busy=0 latches base, exp, n and r2, clears err, and sets busy next cycle.
  - start with busy=1 is ignored; latched operands are unaffected by later input changes.
- Montgomery multiply MM(a,b) = a·b·R^-1 mod n:
  - WIDTH+2 bit internal accumulator.
  - 1 load cycle, then WIDTH iterations: acc = (acc + a_i·b + q·n) >> 1, with q = LSB of (acc + a_i·b).
  - Then 1 conditional-subtract cycle (acc >= n -> acc - n).
  - Exactly L = WIDTH+2 cycles per operation; output < n.
- States:
  - IDLE -> start -> CHECK.
  - CHECK (1 cycle):
    - n[0]==0 -> DONE with err=1, result=0.
    - Otherwise -> SCAN with bit index = EXP_WIDTH-1.
  - SCAN (1 cycle per bit):
    - While exp[idx]==0 and idx>0, decrement idx.
    - If the whole exponent is 0, flag exp_zero.
    - -> TO_MONT_B.
  - TO_MONT_B: bm = MM(base, r2) -> TO_MONT_A.
  - TO_MONT_A: acc = MM(1, r2) = R mod n.
    - exp_zero -> FROM_MONT.
    - Otherwise -> SQUARE.
  - SQUARE: acc = MM(acc, acc).
    - exp[idx]=1 -> MULT.
    - Otherwise: idx==0 -> FROM_MONT; else decrement idx and stay in SQUARE.
  - MULT: acc = MM(acc, bm).
    - idx==0 -> FROM_MONT.
    - Otherwise decrement idx -> SQUARE.
  - FROM_MONT: result = MM(acc, 1) -> DONE.
  - DONE (1 cycle): done=1, busy=1 -> IDLE (busy=0 next cycle).
- Latency from the accept edge to the done cycle is exactly 1 + Z + (3 + B + H)·L.
  - Z = leading-zero count of exp (CHECK+SCAN combined). With exp==0, Z=EXP_WIDTH and B=H=0.
  - B = index of top set bit + 1.
  - H = popcount(exp).
  - Even n: done on the 2nd cycle after accept.
- Boundary cases:
  - exp==0 -> result = 1 mod n (0 if n==1).
  - base==0 with exp>0 -> 0.
  - n==1 -> result 0.
  - base>=n or wrong r2 -> result undefined, no hang, latency formula still holds.
- start asserted in the DONE cycle is ignored, because busy=1.

Test Plan:
- WIDTH=8, EXP_WIDTH=8: n=61, r2=22, base=7, exp=13 -> done exactly 105 cycles after accept, result=55, err=0.
- Same config, exp=0, base=7 -> result=1, latency 1+8+3·10=39. Then base=0, exp=1 -> result=0.
- n=60 (even), any operands -> done on 2nd cycle after accept, err=1, result=0. A following valid start clears err.
- start held high for the whole operation, and a second start with different operands mid-run -> only the first is computed (result=55). Inputs changed after accept have no effect.
- sys_rst_n low for one cycle during SQUARE -> next cycle busy=0, done=0, result=0, no done pulse. A fresh start then yields the correct result.
- WIDTH=64, EXP_WIDTH=17, random odd n, base<n, exp=65537, host-computed r2 -> result matches reference model pow(base,65537,n). Latency = 1+0+(3+17+2)·66 = 1453.

Source files
------------

// File: rtl/mont_exp_param.sv
// rtl/mont_exp_param.sv - base^exp mod n via left-to-right square-and-multiply
// over a shared radix-2 bit-serial Montgomery multiplier (WIDTH+2 cycles per product).
module mont_exp_param #(
    parameter int WIDTH     = 2048,
    parameter int EXP_WIDTH = 2048
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     r2,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [IW-1:0]    IDX_TOP  = IW'(EXP_WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_SCAN, S_TO_MONT_B, S_TO_MONT_A,
        S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     base_r, n_r, r2_r, bm, x;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [IW-1:0]        idx;
    logic                 exp_zero;
    logic [WIDTH-1:0]     mm_a, mm_b;
    logic [WIDTH+1:0]     mm_acc;
    logic [CW-1:0]        cnt;

    logic                 mm_active, mm_last;
    logic [WIDTH-1:0]     ld_a, ld_b, mm_out;
    logic [WIDTH+2:0]     mm_sum, mm_red;
    logic [WIDTH+1:0]     mm_next;
    logic [IW-1:0]        idx_m1;

    // Operand routing for whichever product the current state computes.
    always_comb begin
        ld_a      = x;
        ld_b      = x;
        mm_active = 1'b1;
        case (state)
            S_TO_MONT_B: begin ld_a = base_r; ld_b = r2_r; end
            S_TO_MONT_A: begin ld_a = ONE;    ld_b = r2_r; end
            S_SQUARE:    begin end
            S_MULT:      ld_b = bm;
            S_FROM_MONT: ld_b = ONE;
            default:     mm_active = 1'b0;
        endcase
    end

    always_comb begin
        mm_sum  = {1'b0, mm_acc} + (mm_a[0] ? {3'b000, mm_b} : '0);
        mm_red  = mm_sum + (mm_sum[0] ? {3'b000, n_r} : '0);
        mm_next = (WIDTH+2)'(mm_red >> 1);
        mm_out  = (mm_acc >= {2'b00, n_r}) ? WIDTH'(mm_acc - {2'b00, n_r})
                                           : mm_acc[WIDTH-1:0];
        mm_last = (cnt == CNT_LAST);
        idx_m1  = idx - IDX_ONE;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            base_r   <= '0;
            exp_r    <= '0;
            n_r      <= '0;
            r2_r     <= '0;
            bm       <= '0;
            x        <= '0;
            idx      <= '0;
            exp_zero <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_acc   <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;

            // cnt 0: load, 1..WIDTH: iterate, WIDTH+1: final subtract/writeback.
            if (mm_active) begin
                if (cnt == '0) begin
                    mm_a   <= ld_a;
                    mm_b   <= ld_b;
                    mm_acc <= '0;
                    cnt    <= cnt + CNT_ONE;
                end else if (!mm_last) begin
                    mm_acc <= mm_next;
                    mm_a   <= mm_a >> 1;
                    cnt    <= cnt + CNT_ONE;
                end else begin
                    cnt <= '0;
                end
            end

            case (state)
                S_IDLE: if (start) begin
                    base_r <= base;
                    exp_r  <= exp;
                    n_r    <= n;
                    r2_r   <= r2;
                    err    <= 1'b0;
                    busy   <= 1'b1;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    idx      <= IDX_TOP;
                    exp_zero <= 1'b0;
                    if (!n_r[0]) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= exp_r[IDX_TOP] ? S_TO_MONT_B : S_SCAN;
                    end
                end
                // Each cycle consumes one known-zero bit and looks ahead one bit,
                // so skipping costs exactly one cycle per leading zero.
                S_SCAN: begin
                    if (idx == '0) begin
                        exp_zero <= 1'b1;
                        state    <= S_TO_MONT_B;
                    end else begin
                        idx <= idx_m1;
                        if (exp_r[idx_m1]) state <= S_TO_MONT_B;
                    end
                end
                S_TO_MONT_B: if (mm_last) begin
                    bm    <= mm_out;
                    state <= S_TO_MONT_A;
                end
                S_TO_MONT_A: if (mm_last) begin
                    x     <= mm_out;
                    state <= exp_zero ? S_FROM_MONT : S_SQUARE;
                end
                S_SQUARE: if (mm_last) begin
                    x <= mm_out;
                    if (exp_r[idx])     state <= S_MULT;
                    else if (idx == '0) state <= S_FROM_MONT;
                    else                idx   <= idx_m1;
                end
                S_MULT: if (mm_last) begin
                    x <= mm_out;
                    if (idx == '0) begin
                        state <= S_FROM_MONT;
                    end else begin
                        idx   <= idx_m1;
                        state <= S_SQUARE;
                    end
                end
                S_FROM_MONT: if (mm_last) begin
                    result <= mm_out;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_param.sv
// tb/tb_mont_exp_param.sv - vector table plus hand sequences for mont_exp_param,
// results checked through per-instance expectation queues.
module tb_mont_exp_param;

    logic clk;
    logic sys_rst_n;

    logic        start8, busy8, done8, err8;
    logic [7:0]  base8, exp8, n8, r28, result8;

    logic        start64, busy64, done64, err64;
    logic [63:0] base64, n64, r264, result64;
    logic [16:0] exp64;

    mont_exp_param #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .sys_rst_n(sys_rst_n), .start(start8), .base(base8), .exp(exp8),
        .n(n8), .r2(r28), .busy(busy8), .done(done8), .err(err8), .result(result8)
    );

    mont_exp_param #(.WIDTH(64), .EXP_WIDTH(17)) dut64 (
        .clk(clk), .sys_rst_n(sys_rst_n), .start(start64), .base(base64), .exp(exp64),
        .n(n64), .r2(r264), .busy(busy64), .done(done64), .err(err64), .result(result64)
    );

    typedef struct {
        logic [63:0] base;
        logic [63:0] exp;
        logic [63:0] n;
        logic [63:0] r2;
        logic [63:0] res;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        int          acc;
    } sb_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt8 = 0;
    sb_t  q8[$];
    sb_t  q64[$];
    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r;
        if (m == 64'd1) return 64'd0;
        r = 128'd1;
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r[63:0];
    endfunction

    function automatic logic [63:0] r2_of(input logic [63:0] m, input int w);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < 2 * w; i++) r = (r << 1) % m;
        return r[63:0];
    endfunction

    always begin
        sb_t e;
        @(posedge clk); #1;
        if (done8 === 1'b1) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done8: done=1 expected no done");
            end else begin
                e = q8.pop_front();
                check("result8", result8, e.res);
                check("err8", err8, e.err);
                check("latency8", cyc - e.acc, e.lat);
                check("busy_at_done8", busy8, 1);
            end
        end
    end

    always begin
        sb_t e;
        @(posedge clk); #1;
        if (done64 === 1'b1) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done64: done=1 expected no done");
            end else begin
                e = q64.pop_front();
                check("result64", result64, e.res);
                check("err64", err64, e.err);
                check("latency64", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_q8(input int budget);
        for (int i = 0; i < budget && q8.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (q8.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout8: no done after %0d cycles, expected done", budget);
            q8.delete();
        end
    endtask

    task automatic run8(input vec_t v);
        base8 = v.base[7:0]; exp8 = v.exp[7:0]; n8 = v.n[7:0]; r28 = v.r2[7:0];
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy_after_accept8", busy8, 1);
        check("err_clear_on_accept8", err8, 0);
        q8.push_back(sb_t'{v.res, v.err, v.lat, cyc});
        wait_q8(400);
        @(posedge clk); #1;
        check("busy_clear8", busy8, 0);
    endtask

    task automatic run64(input logic [63:0] b, input logic [63:0] m,
                         input logic [63:0] r, input logic [63:0] res);
        base64 = b; exp64 = 17'd65537; n64 = m; r264 = r;
        start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        check("busy_after_accept64", busy64, 1);
        q64.push_back(sb_t'{res, 1'b0, 1453, cyc});
        for (int i = 0; i < 2000 && q64.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (q64.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout64: no done after 2000 cycles, expected done");
            q64.delete();
        end
        @(posedge clk); #1;
        check("busy_clear64", busy64, 0);
    endtask

    initial begin
        logic [63:0] nn, bb;
        int dcnt;
        sys_rst_n = 1'b0;
        start8 = 1'b0; base8 = '0; exp8 = '0; n8 = '0; r28 = '0;
        start64 = 1'b0; base64 = '0; exp64 = '0; n64 = '0; r264 = '0;

        vecs[0] = '{64'd7,   64'd13,  64'd61,  64'd22, 64'd55,  1'b0, 105};
        vecs[1] = '{64'd7,   64'd0,   64'd61,  64'd22, 64'd1,   1'b0, 39};
        vecs[2] = '{64'd0,   64'd1,   64'd61,  64'd22, 64'd0,   1'b0, 58};
        vecs[3] = '{64'd5,   64'd3,   64'd60,  64'd0,  64'd0,   1'b1, 1};
        vecs[4] = '{64'd0,   64'd5,   64'd1,   64'd0,  64'd0,   1'b0, 86};
        vecs[5] = '{64'd200, 64'd255, 64'd251, 64'd25, 64'd102, 1'b0, 191};
        vecs[6] = '{64'd2,   64'd128, 64'd255, 64'd1,  64'd1,   1'b0, 121};
        vecs[7] = '{64'd0,   64'd0,   64'd1,   64'd0,  64'd0,   1'b0, 39};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_err8", err8, 0);
        check("reset_result8", result8, 0);
        check("reset_busy64", busy64, 0);
        check("reset_done64", done64, 0);
        check("reset_err64", err64, 0);
        check("reset_result64", result64, 0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run8(vecs[i]);

        // err stays up after an even-modulus run until the next accepted start
        run8(vecs[3]);
        repeat (3) @(posedge clk);
        #1;
        check("err_held8", err8, 1);
        run8(vecs[0]);

        // start held for the whole run, operands changed after accept
        base8 = 8'd7; exp8 = 8'd13; n8 = 8'd61; r28 = 8'd22;
        start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back(sb_t'{64'd55, 1'b0, 105, cyc});
        base8 = 8'd3; exp8 = 8'd200; n8 = 8'd59; r28 = 8'd5;
        for (int i = 0; i < 200 && done8 !== 1'b1; i++) begin
            @(posedge clk); #2;
        end
        check("hold_run_completed8", q8.size(), 0);
        @(posedge clk); #1;
        start8 = 1'b0;
        check("start_in_done_ignored8", busy8, 0);
        check("result_held8", result8, 55);
        q8.delete();

        // reset pulse while squaring abandons the run silently
        base8 = 8'd7; exp8 = 8'd13; n8 = 8'd61; r28 = 8'd22;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        sys_rst_n = 1'b0;
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        check("midrun_reset_busy8", busy8, 0);
        check("midrun_reset_done8", done8, 0);
        check("midrun_reset_result8", result8, 0);
        check("midrun_reset_err8", err8, 0);
        dcnt = done_cnt8;
        repeat (120) @(posedge clk);
        #1;
        check("no_done_after_reset8", done_cnt8, dcnt);
        run8(vecs[0]);

        for (int k = 0; k < 2; k++) begin
            nn = {$urandom(), $urandom()} | 64'h8000_0000_0000_0001;
            bb = {$urandom(), $urandom()} % nn;
            run64(bb, nn, r2_of(nn, 64), modexp(bb, 64'd65537, nn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
